// File: rtl/clkdiv_arbiter_if.sv
// rtl/clkdiv_arbiter_if.sv - requester and divider signal bundle for clkdiv_arbiter
interface clkdiv_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*8-1:0] req_div;
   logic [NUM_REQ*8-1:0] req_len;
   logic                 div_clk_in;
   logic                 div_reset;
   logic                 div_enable;
   logic [7:0]           div_value;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 busy;
   logic                 done;
   logic                 aborted;

   modport master (
      output req, req_div, req_len, div_clk_in,
      input  div_reset, div_enable, div_value, grant, grant_idx, busy, done, aborted
   );

   modport slave (
      input  req, req_div, req_len, div_clk_in,
      output div_reset, div_enable, div_value, grant, grant_idx, busy, done, aborted
   );
endinterface

// File: rtl/clkdiv_arbiter.sv
// rtl/clkdiv_arbiter.sv - arbitrates bursts on one shared clock divider
// Define CLKDIV_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module clkdiv_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input logic             clk,
   input logic             reset,
   clkdiv_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t             state;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   grant_idx_q;
   logic [7:0]         div_value_q;
   logic [7:0]         len_q;
   logic [7:0]         edge_cnt;
   logic               div_reset_q;
   logic               div_enable_q;
   logic               aborted_q;
   logic               prev_clk;

   logic [IDX_W-1:0]   base;
   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [NUM_REQ-1:0] sel_grant;
   logic [7:0]         sel_div;
   logic [7:0]         sel_len;
   logic               held;
   logic               rise;

`ifdef CLKDIV_ARB_FIXED_PRIO_EN
   assign base = '0;
`else
   logic [IDX_W-1:0]   rr_ptr;
   assign base = rr_ptr;
`endif

   // Pick the requester with the smallest cyclic distance from base.
   always_comb begin
      int best_off;
      int off;
      best_off  = NUM_REQ;
      off       = 0;
      sel_idx   = '0;
      sel_grant = '0;
      sel_div   = '0;
      sel_len   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         off = (i + NUM_REQ - int'(base)) % NUM_REQ;
         if (bus.req[i] && off < best_off) begin
            best_off     = off;
            sel_idx      = IDX_W'(i);
            sel_grant    = '0;
            sel_grant[i] = 1'b1;
            sel_div      = bus.req_div[8*i +: 8];
            sel_len      = bus.req_len[8*i +: 8];
         end
      end
   end

   assign sel_found = |bus.req;
   assign held      = |(bus.req & grant_q);
   assign rise      = bus.div_clk_in & ~prev_clk;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         grant_q      <= '0;
         grant_idx_q  <= '0;
         div_value_q  <= '0;
         len_q        <= '0;
         edge_cnt     <= '0;
         div_reset_q  <= 1'b1;
         div_enable_q <= 1'b0;
         aborted_q    <= 1'b0;
         prev_clk     <= 1'b0;
`ifndef CLKDIV_ARB_FIXED_PRIO_EN
         rr_ptr       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               div_reset_q  <= 1'b1;
               div_enable_q <= 1'b0;
               if (sel_found) begin
                  div_value_q <= sel_div;
                  len_q       <= sel_len;
                  grant_q     <= sel_grant;
                  grant_idx_q <= sel_idx;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               edge_cnt <= '0;
               prev_clk <= 1'b0;
`ifndef CLKDIV_ARB_FIXED_PRIO_EN
               rr_ptr   <= (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
`endif
               if (len_q == 8'd0) begin
                  aborted_q <= 1'b0;
                  state     <= DONE;
               end else begin
                  div_reset_q  <= 1'b0;
                  div_enable_q <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               prev_clk <= bus.div_clk_in;
               // A dropped request wins over a completing edge in the same cycle.
               if (!held) begin
                  aborted_q    <= 1'b1;
                  div_reset_q  <= 1'b1;
                  div_enable_q <= 1'b0;
                  state        <= DONE;
               end else if (rise) begin
                  edge_cnt <= edge_cnt + 8'd1;
                  if (edge_cnt + 8'd1 == len_q) begin
                     aborted_q    <= 1'b0;
                     div_reset_q  <= 1'b1;
                     div_enable_q <= 1'b0;
                     state        <= DONE;
                  end
               end
            end
            DONE: begin
               grant_q   <= '0;
               aborted_q <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.div_reset  = div_reset_q;
   assign bus.div_enable = div_enable_q;
   assign bus.div_value  = div_value_q;
   assign bus.grant      = grant_q;
   assign bus.grant_idx  = grant_idx_q;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.aborted    = aborted_q;
endmodule
